// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//    Stall/flush sequencer for the 5-stage pipeline. Handles the hazards the
//    EX forwarding network cannot resolve:
//       - load-use bubbles
//       - multi-cycle MDU operations
//       - data-memory wait states
//       - EX branch/jump redirects
//    Also keeps a saturating stall-cycle counter and a sticky MDU timeout flag.
//
// Ports
//    clk, rst                      clock, asynchronous active-high reset
//    hazard_ctrl_id_*              source operands of the instruction in ID
//    hazard_ctrl_id2ex_*           destination / load flag of the instruction in EX
//    hazard_ctrl_ex_mdu_op_i       EX holds a mul/div
//    hazard_ctrl_ex_mdu_done_i     MDU result valid pulse
//    hazard_ctrl_ex_redirect_i     EX resolved a taken branch/jump
//    hazard_ctrl_mem_req_i/ready_i data memory handshake of the MEM instruction
//    hazard_ctrl_stall_*_o         hold enables for pc and pipeline registers
//    hazard_ctrl_flush_*_o         bubble-insert enables for pipeline registers
//    hazard_ctrl_mdu_start_o       one-cycle MDU launch pulse
//    hazard_ctrl_stall_cnt_o       saturating count of cycles with pc held
//    hazard_ctrl_mdu_timeout_o     sticky MDU timeout error
module hazard_ctrl #(
   parameter int REG_INDEX_SIZE = 5,
   parameter int MDU_TIMEOUT    = 64,
   parameter int CNT_W          = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_INDEX_SIZE-1:0] hazard_ctrl_id_rs1_index_i,
   input  logic [REG_INDEX_SIZE-1:0] hazard_ctrl_id_rs2_index_i,
   input  logic                      hazard_ctrl_id_rs1_used_i,
   input  logic                      hazard_ctrl_id_rs2_used_i,
   input  logic [REG_INDEX_SIZE-1:0] hazard_ctrl_id2ex_rd_index_i,
   input  logic                      hazard_ctrl_id2ex_is_load_i,
   input  logic                      hazard_ctrl_ex_mdu_op_i,
   input  logic                      hazard_ctrl_ex_mdu_done_i,
   input  logic                      hazard_ctrl_ex_redirect_i,
   input  logic                      hazard_ctrl_mem_req_i,
   input  logic                      hazard_ctrl_mem_ready_i,
   output logic                      hazard_ctrl_stall_pc_o,
   output logic                      hazard_ctrl_stall_if2id_o,
   output logic                      hazard_ctrl_stall_id2ex_o,
   output logic                      hazard_ctrl_stall_ex2mem_o,
   output logic                      hazard_ctrl_flush_if2id_o,
   output logic                      hazard_ctrl_flush_id2ex_o,
   output logic                      hazard_ctrl_flush_ex2mem_o,
   output logic                      hazard_ctrl_flush_mem2wb_o,
   output logic                      hazard_ctrl_mdu_start_o,
   output logic [CNT_W-1:0]          hazard_ctrl_stall_cnt_o,
   output logic                      hazard_ctrl_mdu_timeout_o
);

   typedef enum logic [1:0] {IDLE, MDU_BUSY, MDU_HOLD} state_t;

   localparam logic [7:0] BUSY_LAST = 8'(MDU_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] busy_cnt, busy_cnt_nxt;
   logic       memw, lu;
   logic       mdu_stall, mdu_start, timeout_set;

   assign memw = hazard_ctrl_mem_req_i & ~hazard_ctrl_mem_ready_i;

   assign lu = hazard_ctrl_id2ex_is_load_i
             & (hazard_ctrl_id2ex_rd_index_i != '0)
             & ((hazard_ctrl_id_rs1_used_i & (hazard_ctrl_id_rs1_index_i == hazard_ctrl_id2ex_rd_index_i))
              | (hazard_ctrl_id_rs2_used_i & (hazard_ctrl_id_rs2_index_i == hazard_ctrl_id2ex_rd_index_i)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                     <= IDLE;
         busy_cnt                  <= '0;
         hazard_ctrl_mdu_timeout_o <= 1'b0;
      end else begin
         state    <= state_nxt;
         busy_cnt <= busy_cnt_nxt;
         if (timeout_set) hazard_ctrl_mdu_timeout_o <= 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      busy_cnt_nxt = busy_cnt;
      mdu_stall    = 1'b0;
      mdu_start    = 1'b0;
      timeout_set  = 1'b0;
      case (state)
         IDLE: begin
            if (hazard_ctrl_ex_mdu_op_i) begin
               mdu_stall = 1'b1;
               // Launch is deferred while MEM waits; the op simply stays in EX.
               if (!memw) begin
                  mdu_start    = 1'b1;
                  state_nxt    = MDU_BUSY;
                  busy_cnt_nxt = '0;
               end
            end
         end
         MDU_BUSY: begin
            busy_cnt_nxt = busy_cnt + 8'd1;
            if (hazard_ctrl_ex_mdu_done_i) begin
               // Result is captured in EX; if MEM is still waiting, hold it there.
               state_nxt = memw ? MDU_HOLD : IDLE;
            end else begin
               mdu_stall = 1'b1;
               if (busy_cnt == BUSY_LAST) begin
                  timeout_set = 1'b1;
                  state_nxt   = IDLE;
               end
            end
         end
         MDU_HOLD: begin
            if (memw) mdu_stall = 1'b1;
            else      state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Priority chain; reset forces every control low combinationally so the
   // pipeline sees a clean state without waiting for a clock edge.
   always_comb begin
      hazard_ctrl_stall_pc_o     = 1'b0;
      hazard_ctrl_stall_if2id_o  = 1'b0;
      hazard_ctrl_stall_id2ex_o  = 1'b0;
      hazard_ctrl_stall_ex2mem_o = 1'b0;
      hazard_ctrl_flush_if2id_o  = 1'b0;
      hazard_ctrl_flush_id2ex_o  = 1'b0;
      hazard_ctrl_flush_ex2mem_o = 1'b0;
      hazard_ctrl_flush_mem2wb_o = 1'b0;
      hazard_ctrl_mdu_start_o    = mdu_start & ~rst;
      if (!rst) begin
         if (memw) begin
            hazard_ctrl_stall_pc_o     = 1'b1;
            hazard_ctrl_stall_if2id_o  = 1'b1;
            hazard_ctrl_stall_id2ex_o  = 1'b1;
            hazard_ctrl_stall_ex2mem_o = 1'b1;
            hazard_ctrl_flush_mem2wb_o = 1'b1;
         end else if (mdu_stall) begin
            hazard_ctrl_stall_pc_o     = 1'b1;
            hazard_ctrl_stall_if2id_o  = 1'b1;
            hazard_ctrl_stall_id2ex_o  = 1'b1;
            hazard_ctrl_flush_ex2mem_o = 1'b1;
         end else if (hazard_ctrl_ex_redirect_i) begin
            hazard_ctrl_flush_if2id_o  = 1'b1;
            hazard_ctrl_flush_id2ex_o  = 1'b1;
         end else if (lu) begin
            hazard_ctrl_stall_pc_o     = 1'b1;
            hazard_ctrl_stall_if2id_o  = 1'b1;
            hazard_ctrl_flush_id2ex_o  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hazard_ctrl_stall_cnt_o <= '0;
      end else if (hazard_ctrl_stall_pc_o && (hazard_ctrl_stall_cnt_o != '1)) begin
         hazard_ctrl_stall_cnt_o <= hazard_ctrl_stall_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   // Expected control vector layout:
   // [8] stall_pc [7] stall_if2id [6] stall_id2ex [5] stall_ex2mem
   // [4] flush_if2id [3] flush_id2ex [2] flush_ex2mem [1] flush_mem2wb [0] mdu_start
   localparam logic [8:0] NONE  = 9'b000000000;
   localparam logic [8:0] LU    = 9'b110001000;
   localparam logic [8:0] MDU   = 9'b111000100;
   localparam logic [8:0] MEMW  = 9'b111100010;
   localparam logic [8:0] RED   = 9'b000011000;
   localparam logic [8:0] START = 9'b000000001;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1, rs2, rd;
   logic        rs1_used, rs2_used, is_load;
   logic        mdu_op, mdu_done, redirect, mem_req, mem_ready;
   logic        stall_pc, stall_if2id, stall_id2ex, stall_ex2mem;
   logic        flush_if2id, flush_id2ex, flush_ex2mem, flush_mem2wb;
   logic        mdu_start, mdu_timeout;
   logic [31:0] stall_cnt;

   typedef struct {
      string       tag;
      logic [8:0]  v;
      int unsigned cnt;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned exp_cnt = 0;
   int unsigned checks = 0;
   int unsigned failures = 0;

   hazard_ctrl #(.REG_INDEX_SIZE(5), .MDU_TIMEOUT(8), .CNT_W(32)) dut (
      .clk                          (clk),
      .rst                          (rst),
      .hazard_ctrl_id_rs1_index_i   (rs1),
      .hazard_ctrl_id_rs2_index_i   (rs2),
      .hazard_ctrl_id_rs1_used_i    (rs1_used),
      .hazard_ctrl_id_rs2_used_i    (rs2_used),
      .hazard_ctrl_id2ex_rd_index_i (rd),
      .hazard_ctrl_id2ex_is_load_i  (is_load),
      .hazard_ctrl_ex_mdu_op_i      (mdu_op),
      .hazard_ctrl_ex_mdu_done_i    (mdu_done),
      .hazard_ctrl_ex_redirect_i    (redirect),
      .hazard_ctrl_mem_req_i        (mem_req),
      .hazard_ctrl_mem_ready_i      (mem_ready),
      .hazard_ctrl_stall_pc_o       (stall_pc),
      .hazard_ctrl_stall_if2id_o    (stall_if2id),
      .hazard_ctrl_stall_id2ex_o    (stall_id2ex),
      .hazard_ctrl_stall_ex2mem_o   (stall_ex2mem),
      .hazard_ctrl_flush_if2id_o    (flush_if2id),
      .hazard_ctrl_flush_id2ex_o    (flush_id2ex),
      .hazard_ctrl_flush_ex2mem_o   (flush_ex2mem),
      .hazard_ctrl_flush_mem2wb_o   (flush_mem2wb),
      .hazard_ctrl_mdu_start_o      (mdu_start),
      .hazard_ctrl_stall_cnt_o      (stall_cnt),
      .hazard_ctrl_mdu_timeout_o    (mdu_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic push_exp(input string tag, input logic [8:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
      if (v[8]) exp_cnt++;
   endtask

   task automatic compare_out();
      exp_t       e;
      logic [8:0] obs;
      e   = exp_q.pop_front();
      obs = {stall_pc, stall_if2id, stall_id2ex, stall_ex2mem,
             flush_if2id, flush_id2ex, flush_ex2mem, flush_mem2wb, mdu_start};
      checks++;
      assert (obs === e.v) else begin
         failures++;
         $error("FAIL %s ctrl: got %b expected %b", e.tag, obs, e.v);
      end
      checks++;
      assert (stall_cnt === 32'(e.cnt)) else begin
         failures++;
         $error("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt, e.cnt);
      end
   endtask

   task automatic check_timeout(input string tag, input logic v);
      checks++;
      assert (mdu_timeout === v) else begin
         failures++;
         $error("FAIL %s timeout: got %b expected %b", tag, mdu_timeout, v);
      end
   endtask

   // Inputs are already driven; record expectation, sample mid-cycle, clock it.
   task automatic step(input string tag, input logic [8:0] v);
      push_exp(tag, v);
      @(negedge clk);
      compare_out();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rs1 = '0; rs2 = '0; rd = '0;
      rs1_used = 0; rs2_used = 0; is_load = 0;
      mdu_op = 0; mdu_done = 0; redirect = 0; mem_req = 0; mem_ready = 0;
   endtask

   initial begin
      // Reset with every hazard input asserted: outputs must stay quiet.
      rst = 1;
      clear_inputs();
      is_load = 1; rd = 5; rs2 = 5; rs2_used = 1;
      mdu_op = 1; redirect = 1; mem_req = 1; mem_ready = 0;
      #3;
      push_exp("reset_comb", NONE);
      compare_out();
      check_timeout("reset", 1'b0);
      @(posedge clk); #1;
      push_exp("reset_after_edge", NONE);
      compare_out();
      clear_inputs();
      rst = 0;

      // Load-use on rs2 -> one bubble.
      is_load = 1; rd = 5; rs2 = 5; rs2_used = 1; rs1 = 2; rs1_used = 1;
      step("lu_rs2", LU);
      is_load = 0;
      step("lu_bubble_done", NONE);
      // rd = 0 never hazards.
      is_load = 1; rd = 0; rs1 = 0; rs1_used = 1; rs2 = 0; rs2_used = 1;
      step("lu_rd0", NONE);
      // Matching index but operand unused.
      rd = 7; rs1 = 7; rs1_used = 0; rs2 = 3; rs2_used = 1;
      step("lu_unused", NONE);
      // Load-use on rs1.
      rs1_used = 1;
      step("lu_rs1", LU);
      // Redirect squashes the load-use.
      redirect = 1;
      step("redirect_vs_lu", RED);
      clear_inputs();

      // MDU: launch + 4 busy cycles stalled, advances on done.
      mdu_op = 1;
      step("mdu_launch", MDU | START);
      step("mdu_busy1", MDU);
      redirect = 1;
      step("mdu_busy2_redirect", MDU);
      redirect = 0;
      step("mdu_busy3", MDU);
      step("mdu_busy4", MDU);
      mdu_done = 1;
      step("mdu_done", NONE);
      clear_inputs();
      step("mdu_after", NONE);

      // MDU done while memory waits -> hold, release when ready.
      mdu_op = 1;
      step("hold_launch", MDU | START);
      step("hold_busy1", MDU);
      mem_req = 1; mem_ready = 0;
      step("hold_memw1", MEMW);
      mdu_done = 1;
      step("hold_done_memw", MEMW);
      mdu_done = 0;
      step("hold_memw3", MEMW);
      mem_ready = 1;
      step("hold_release", NONE);
      mem_req = 0; mem_ready = 0;
      step("hold_idle_relaunch", MDU | START);
      mdu_done = 1;
      step("hold_quick_done", NONE);
      clear_inputs();

      // Launch deferred while memory waits.
      mdu_op = 1; mem_req = 1; mem_ready = 0;
      step("defer_memw", MEMW);
      mem_ready = 1;
      step("defer_launch", MDU | START);
      mdu_done = 1;
      step("defer_done", NONE);
      clear_inputs();

      // Timeout after 8 busy cycles without done.
      mdu_op = 1;
      step("to_launch", MDU | START);
      for (int i = 1; i <= 8; i++) begin
         step($sformatf("to_busy%0d", i), MDU);
      end
      push_exp("to_relaunch_idle", MDU | START);
      @(negedge clk);
      compare_out();
      check_timeout("to_set", 1'b1);
      @(posedge clk); #1;
      mdu_done = 1;
      step("to_done", NONE);
      clear_inputs();
      step("to_idle", NONE);
      check_timeout("to_sticky", 1'b1);

      // Asynchronous reset in MDU_BUSY with memory waiting.
      mdu_op = 1;
      step("ar_launch", MDU | START);
      mem_req = 1; mem_ready = 0;
      step("ar_busy_memw", MEMW);
      rst = 1;
      #1;
      exp_cnt = 0;
      push_exp("ar_async", NONE);
      compare_out();
      check_timeout("ar_timeout_clr", 1'b0);
      #1;
      rst = 0;
      mem_req = 0;
      step("ar_idle_launch", MDU | START);
      mdu_done = 1;
      step("ar_done", NONE);
      clear_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline-wide stall/flush sequencer for the 5-stage core.
- Sits beside the ex-stage forwarding logic. Forwarding resolves ordinary RAW hazards; this block covers what forwarding cannot:
  - load-use bubbles
  - multi-cycle MDU ops in EX
  - memory wait states in MEM
  - EX branch/jump redirects
- Drives stall and flush enables of pc, if2id, id2ex, ex2mem and mem2wb. Keeps a stall-cycle counter and an MDU timeout flag.

Parameters:
- REG_INDEX_SIZE, 5, width of register index.
- MDU_TIMEOUT, 64, max MDU busy cycles before error; legal range 2..255.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- hazard_ctrl_id_rs1_index_i  in  REG_INDEX_SIZE  rs1 of instr in ID.
- hazard_ctrl_id_rs2_index_i  in  REG_INDEX_SIZE  rs2 of instr in ID.
- hazard_ctrl_id_rs1_used_i  in  1  ID instr reads rs1.
- hazard_ctrl_id_rs2_used_i  in  1  ID instr reads rs2.
- hazard_ctrl_id2ex_rd_index_i  in  REG_INDEX_SIZE  rd of instr in EX.
- hazard_ctrl_id2ex_is_load_i  in  1  EX instr is a load.
- hazard_ctrl_ex_mdu_op_i  in  1  EX instr is mul/div.
- hazard_ctrl_ex_mdu_done_i  in  1  MDU result valid (pulse).
- hazard_ctrl_ex_redirect_i  in  1  EX resolved taken branch/jump.
- hazard_ctrl_mem_req_i  in  1  MEM instr accesses data memory.
- hazard_ctrl_mem_ready_i  in  1  data memory completes this cycle.
- hazard_ctrl_stall_pc_o  out  1  hold pc.
- hazard_ctrl_stall_if2id_o  out  1  hold if2id.
- hazard_ctrl_stall_id2ex_o  out  1  hold id2ex.
- hazard_ctrl_stall_ex2mem_o  out  1  hold ex2mem.
- hazard_ctrl_flush_if2id_o  out  1  load bubble into if2id.
- hazard_ctrl_flush_id2ex_o  out  1  load bubble into id2ex.
- hazard_ctrl_flush_ex2mem_o  out  1  load bubble into ex2mem.
- hazard_ctrl_flush_mem2wb_o  out  1  load bubble into mem2wb.
- hazard_ctrl_mdu_start_o  out  1  one-cycle MDU launch pulse.
- hazard_ctrl_stall_cnt_o  out  CNT_W  cycles with stall_pc_o=1, saturating.
- hazard_ctrl_mdu_timeout_o  out  1  sticky MDU timeout error.

Behaviour:
- Reset (rst=1, async):
  - state=IDLE, busy counter=0, stall_cnt=0, timeout=0.
  - mdu_start=0; all stall/flush outputs 0 regardless of inputs.
- Hazard terms, combinational:
  - memw = mem_req & ~mem_ready.
  - lu = id2ex_is_load & (id2ex_rd != 0) & ((rs1_used & rs1 == rd) | (rs2_used & rs2 == rd)).
- FSM states: IDLE, MDU_BUSY, MDU_HOLD.
  - IDLE: mdu_op & ~memw → mdu_start=1 for that cycle, go MDU_BUSY, counter=0. If memw is also 1, stay IDLE and launch in the first cycle memw=0.
  - MDU_BUSY:
    - counter increments each cycle.
    - On mdu_done: if memw, go MDU_HOLD; else go IDLE.
    - counter == MDU_TIMEOUT-1 without done → timeout=1 (sticky until reset), go IDLE.
  - MDU_HOLD: result latched in EX; go IDLE on first cycle memw=0.
  - Done-exit cycle (MDU_BUSY with done & ~memw, or MDU_HOLD with ~memw) releases EX; it is a normal advance cycle.
- mdu_stall = 1 when:
  - (IDLE & mdu_op & not the release cycle), or
  - MDU_BUSY & ~done, or
  - MDU_HOLD & memw.
  - Latency: MDU op occupies EX for launch cycle + busy cycles; it advances in the cycle done is seen, if memw=0.
- Output priority, highest first:
  1. memw:
     - stall_pc, stall_if2id, stall_id2ex, stall_ex2mem = 1; flush_mem2wb = 1.
     - Redirect and lu are ignored this cycle.
  2. mdu_stall:
     - stall_pc, stall_if2id, stall_id2ex = 1; flush_ex2mem = 1.
     - Redirect ignored; EX has not advanced.
  3. redirect:
     - flush_if2id = 1, flush_id2ex = 1, no stalls.
     - lu is ignored because the ID instruction is squashed.
  4. lu: stall_pc = 1, stall_if2id = 1, flush_id2ex = 1. Exactly one bubble, since load data is then forwarded from mem2wb.
- A stall and a flush are never asserted on the same register in the same cycle.
- stall_cnt increments on each clock edge where stall_pc_o=1 (rst=0); it holds at all-ones.
- Register index 0 never causes lu.

Test Plan:
- Load-use: id2ex load rd=5, ID rs2=5 used, others idle → stall_pc=stall_if2id=flush_id2ex=1 for exactly 1 cycle, stall_cnt=1. Repeat with rd=0 → no stall.
- MDU: mdu_op=1, done after 4 busy cycles → mdu_start pulses once. stall_pc=1 and flush_ex2mem=1 for 5 cycles; EX advances on the done cycle; state returns IDLE.
- MDU done during memw: mem_req=1, mem_ready=0 for 3 cycles spanning done → state MDU_HOLD. stall_ex2mem=1 and flush_mem2wb=1 for those cycles; IDLE on the cycle mem_ready=1.
- Redirect vs load-use same cycle → flush_if2id=flush_id2ex=1, stall_pc=0. Redirect during MDU_BUSY → ignored, only stalls.
- Timeout: MDU_TIMEOUT=8, done never asserted → timeout=1 after 8 busy cycles, FSM to IDLE; flag stays 1 until rst.
- Async reset mid-MDU_BUSY with memw=1 → all outputs 0 immediately, before the next clk edge; stall_cnt=0; FSM IDLE.
